// File: rtl/tmds_channel_receiver_if.sv
// tmds_channel_receiver_if: raw deserialized word in, decoded symbol and alignment status out
interface tmds_channel_receiver_if;
  logic [9:0] TMDS_data;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       locked;
  logic [3:0] offset;
  modport master (output TMDS_data, input de, ctrl, data, locked, offset);
  modport slave (input TMDS_data, output de, ctrl, data, locked, offset);
endinterface

// File: rtl/tmds_channel_receiver.sv
// tmds_channel_receiver: word alignment by control-token search, then TMDS symbol decode
module tmds_channel_receiver #(
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT = 2048
) (
  input logic clkRGB,
  input logic reset_n,
  tmds_channel_receiver_if.slave tmds
);
  localparam logic [1:0] SEARCH = 2'd0, SLIP = 2'd1, LOCKED = 2'd2;
  localparam logic [9:0] T00 = 10'b1101010100, T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100, T11 = 10'b1010101011;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_TOK = CW'(LOCK_COUNT - 1);
  localparam logic [IW-1:0] LAST_IDLE = IW'(TIMEOUT - 1);
  logic [9:0] d1, d2, aw;
  logic [19:0] hist;
  logic [1:0] state, tc;
  logic [CW-1:0] tokcnt;
  logic [IW-1:0] idle;
  logic tok;
  logic [7:0] b, dec;
  assign hist = {d1, d2};
  always_comb begin
    tok = aw == T00 || aw == T01 || aw == T10 || aw == T11;
    tc = aw == T01 ? 2'b01 : aw == T10 ? 2'b10 : aw == T11 ? 2'b11 : 2'b00;
    b = aw[9] ? ~aw[7:0] : aw[7:0];
    dec = {b[7:1] ^ b[6:0] ^ {7{~aw[8]}}, b[0]};
  end
  always_ff @(posedge clkRGB or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= '0;
      d2 <= '0;
      aw <= '0;
      tmds.de <= 1'b0;
      tmds.ctrl <= 2'b00;
      tmds.data <= 8'h00;
      tmds.locked <= 1'b0;
      tmds.offset <= 4'd0;
      state <= SEARCH;
      tokcnt <= '0;
      idle <= '0;
    end else begin
      d1 <= tmds.TMDS_data;
      d2 <= d1;
      aw <= hist[tmds.offset +: 10];
      tmds.de <= ~tok;
      tmds.ctrl <= tok ? tc : tmds.ctrl;
      tmds.data <= tok ? 8'h00 : dec;
      if (state == SLIP) begin
        state <= SEARCH;
      end else if (state == SEARCH) begin
        if (tok) begin
          idle <= '0;
          tokcnt <= tokcnt + 1'b1;
          if (tokcnt == LAST_TOK) begin
            state <= LOCKED;
            tmds.locked <= 1'b1;
          end
        end else if (idle == LAST_IDLE) begin
          tmds.offset <= tmds.offset == 4'd9 ? 4'd0 : tmds.offset + 4'd1;
          idle <= '0;
          tokcnt <= '0;
          state <= SLIP;
        end else begin
          tokcnt <= '0;
          idle <= idle + 1'b1;
        end
      end else if (state == LOCKED) begin
        if (tok) begin
          idle <= '0;
        end else if (idle == LAST_IDLE) begin
          state <= SEARCH;
          tmds.locked <= 1'b0;
          idle <= '0;
          tokcnt <= '0;
        end else begin
          idle <= idle + 1'b1;
        end
      end else begin
        state <= SEARCH;
      end
    end
  end
endmodule
